// File: rtl/npn_tt_sweeper_pkg.sv
// Shared types and helpers for the NPN truth-table sweeper and its minterm transform.
package npn_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } sweep_state_t;

  localparam int          NUM_MINTERMS = 16;
  localparam logic [7:0]  IDENT_PERM   = 8'hE4;

  typedef struct packed {
    logic [7:0]              perm;
    logic [3:0]              in_neg;
    logic                    out_neg;
    logic [NUM_MINTERMS-1:0] exp_tt;
  } sweep_cfg_t;

  // A perm is legal only if its four 2-bit fields name four distinct minterm bits.
  function automatic logic perm_valid(input logic [7:0] p);
    logic [3:0] seen;
    seen = '0;
    for (int j = 0; j < 4; j++) seen[p[2*j +: 2]] = 1'b1;
    return &seen;
  endfunction

endpackage

// File: rtl/npn_tt_sweeper_xform.sv
// Combinational NPN input transform: minterm index -> function-block inputs.
module npn_xform (
  input  logic [3:0] minterm,
  input  logic [7:0] perm,
  input  logic [3:0] in_neg,
  output logic [3:0] x
);

  always_comb begin
    x = '0;
    for (int j = 0; j < 4; j++) x[j] = minterm[perm[2*j +: 2]] ^ in_neg[j];
  end

endmodule

// File: rtl/npn_tt_sweeper.sv
// Drives all 16 minterms through an NPN transform into a 4-in/1-out block,
// collects the response truth table and compares it against an expected table.
module npn_tt_sweeper
  import npn_sweep_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              perm,
  input  logic [3:0]              in_neg,
  input  logic                    out_neg,
  input  logic [NUM_MINTERMS-1:0] exp_tt,
  output logic [3:0]              x,
  input  logic                    y,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_MINTERMS-1:0] tt,
  output logic                    match,
  output logic                    cfg_err
);

  localparam logic [1:0] DRAIN_LAST = 2'((LAT > 0) ? LAT - 1 : 0);

  sweep_state_t            state, state_nxt;
  sweep_cfg_t              cfg;
  logic [3:0]              idx;
  logic [1:0]              drain_cnt;
  logic [3:0]              x_map;
  logic [NUM_MINTERMS-1:0] tt_nxt;
  logic                    accept, reject, kill;
  logic                    vld_in, smp_vld;
  logic [3:0]              smp_idx;

  assign busy   = (state == S_SWEEP) || (state == S_DRAIN);
  assign done   = (state == S_DONE);
  assign accept = (state == S_IDLE) && start && perm_valid(perm);
  assign reject = (state == S_IDLE) && start && !perm_valid(perm);
  assign kill   = busy && abort;

  npn_xform u_xform (
    .minterm (idx),
    .perm    (cfg.perm),
    .in_neg  (cfg.in_neg),
    .x       (x_map)
  );

  assign x = busy ? x_map : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SWEEP;
      S_SWEEP: begin
        if (kill)            state_nxt = S_IDLE;
        else if (idx == 4'd15) state_nxt = (LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (kill)                         state_nxt = S_IDLE;
        else if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cfg       <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_err   <= reject;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (accept) begin
        cfg <= '{perm: perm, in_neg: in_neg, out_neg: out_neg, exp_tt: exp_tt};
        idx <= '0;
      end else if (state == S_SWEEP && idx != 4'd15) begin
        idx <= idx + 4'd1;
      end
    end
  end

  // (valid, index) travel alongside the block's internal registers so each
  // response lands in the tt bit of the minterm that produced it.
  assign vld_in = (state == S_SWEEP) && !abort;

  if (LAT == 0) begin : g_comb
    assign smp_vld = vld_in;
    assign smp_idx = idx;
  end else begin : g_pipe
    logic [LAT:1]      vld_pipe;
    logic [LAT:1][3:0] idx_pipe;

    always_ff @(posedge clk) begin
      if (rst || kill) begin
        vld_pipe <= '0;
        idx_pipe <= '0;
      end else begin
        vld_pipe[1] <= vld_in;
        idx_pipe[1] <= idx;
        for (int s = 2; s <= LAT; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          idx_pipe[s] <= idx_pipe[s-1];
        end
      end
    end

    assign smp_vld = vld_pipe[LAT];
    assign smp_idx = idx_pipe[LAT];
  end

  always_comb begin
    tt_nxt = tt;
    if (accept)       tt_nxt = '0;
    else if (smp_vld) tt_nxt[smp_idx] = y ^ cfg.out_neg;
  end

  // match is evaluated on the final tt, including the sample landing this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt    <= '0;
      match <= 1'b0;
    end else begin
      tt <= tt_nxt;
      if (accept || kill)         match <= 1'b0;
      else if (state_nxt == S_DONE) match <= (tt_nxt == cfg.exp_tt);
    end
  end

endmodule

// File: tb/tb_npn_tt_sweeper.sv
// Directed bench: two sweepers (LAT=0 combinational block, LAT=2 registered block).
module tb_npn_tt_sweeper;

  logic        clk = 1'b0;
  logic        rst, start0, start2, abort, out_neg, fsel, sel2;
  logic [7:0]  perm;
  logic [3:0]  in_neg;
  logic [15:0] exp_tt;
  logic [3:0]  x0, x2;
  logic        y0, y2, p1, p2;
  logic        busy0, busy2, done0, done2, match0, match2, cerr0, cerr2;
  logic [15:0] tt0, tt2;
  logic        c_busy, c_done, c_match;
  logic [15:0] c_tt;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  npn_tt_sweeper #(.LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .perm(perm),
    .in_neg(in_neg), .out_neg(out_neg), .exp_tt(exp_tt), .x(x0), .y(y0),
    .busy(busy0), .done(done0), .tt(tt0), .match(match0), .cfg_err(cerr0)
  );

  npn_tt_sweeper #(.LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .perm(perm),
    .in_neg(in_neg), .out_neg(out_neg), .exp_tt(exp_tt), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .tt(tt2), .match(match2), .cfg_err(cerr2)
  );

  // Function blocks: fsel=0 -> y=x0, fsel=1 -> AND4; second copy has 2 register stages.
  assign y0 = fsel ? (&x0) : x0[0];
  always @(posedge clk) begin
    p1 <= fsel ? (&x2) : x2[0];
    p2 <= p1;
  end
  assign y2 = p2;

  assign c_busy  = sel2 ? busy2  : busy0;
  assign c_done  = sel2 ? done2  : done0;
  assign c_match = sel2 ? match2 : match0;
  assign c_tt    = sel2 ? tt2    : tt0;

  typedef struct packed {
    logic        lat2;
    logic        fsel;
    logic [7:0]  perm;
    logic [3:0]  in_neg;
    logic        out_neg;
    logic [15:0] exp_tt;
    logic [15:0] tt;
    logic        match;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Called in the first cycle after start acceptance (n0 = 1); bounded wait for done.
  task automatic wait_done(input int n0, output int n, output int bn, output bit got);
    n = n0; bn = 0; got = 0;
    while (n < 80) begin
      if (c_done) begin got = 1; break; end
      if (c_busy) bn++;
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n, bn, lat;
    bit got;
    lat = v.lat2 ? 2 : 0;
    sel2 = v.lat2; fsel = v.fsel; perm = v.perm; in_neg = v.in_neg;
    out_neg = v.out_neg; exp_tt = v.exp_tt;
    if (v.lat2) start2 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start2 = 1'b0;
    wait_done(1, n, bn, got);
    if (!got) $display("FAIL vec%0d_timeout: got no done expected done", k);
    chk($sformatf("vec%0d_done_cycle", k), got ? n : 0, 17 + lat);
    chk($sformatf("vec%0d_busy_cycles", k), bn, 16 + lat);
    chk($sformatf("vec%0d_tt", k), c_tt, v.tt);
    chk($sformatf("vec%0d_match", k), c_match, v.match);
    tick();  // next start lands in the cycle after done
  endtask

  initial begin
    int n, bn, dn;
    bit got;
    //             lat2 fsel perm   in_neg  oneg exp_tt    tt        match
    vecs[0] = '{1'b0, 1'b0, 8'hE4, 4'b0000, 1'b0, 16'hAAAA, 16'hAAAA, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hE4, 4'b0001, 1'b0, 16'h5555, 16'h5555, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'hE1, 4'b0000, 1'b0, 16'hCCCC, 16'hCCCC, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'hE4, 4'b0000, 1'b1, 16'h5555, 16'h5555, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'hE4, 4'b0000, 1'b0, 16'hAAAB, 16'hAAAA, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h1B, 4'b0000, 1'b0, 16'hFF00, 16'hFF00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'hE4, 4'b0000, 1'b0, 16'h8000, 16'h8000, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'hE4, 4'b1111, 1'b0, 16'h0000, 16'h0001, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'hE4, 4'b0000, 1'b0, 16'h8000, 16'h8000, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 8'hE1, 4'b0000, 1'b0, 16'hCCCC, 16'hCCCC, 1'b1};

    rst = 1'b1; start0 = 0; start2 = 0; abort = 0; out_neg = 0; fsel = 0; sel2 = 0;
    perm = 8'hE4; in_neg = 0; exp_tt = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_x", {x2, x0}, 8'h00);
    chk("reset_flags", {busy0, done0, match0, cerr0, busy2, done2, match2, cerr2}, 8'h00);
    chk("reset_tt", {tt2, tt0}, 32'h0);

    for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

    // Duplicate perm index: rejected with a single cfg_err pulse.
    sel2 = 0; perm = 8'h00; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("cfg_err_pulse", cerr0, 1'b1);
    chk("cfg_err_busy", busy0, 1'b0);
    tick();
    chk("cfg_err_clear", cerr0, 1'b0);
    dn = 0;
    repeat (20) begin if (done0 || busy0) dn++; tick(); end
    chk("cfg_err_no_sweep", dn, 0);

    // Start while busy is ignored, including its new config.
    fsel = 0; perm = 8'hE4; in_neg = 0; out_neg = 0; exp_tt = 16'hAAAA; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    perm = 8'hE1; in_neg = 4'hF; exp_tt = 16'hCCCC; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done(6, n, bn, got);
    chk("busy_start_done_cycle", got ? n : 0, 17);
    chk("busy_start_tt", tt0, 16'hAAAA);
    chk("busy_start_match", match0, 1'b1);
    tick();

    // Abort at minterm 7: idle next cycle, no done, match cleared.
    perm = 8'hE4; in_neg = 0; exp_tt = 16'hAAAA; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (7) tick();
    chk("abort_at_m7_x", x0, 4'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {busy0, done0, match0}, 3'b000);
    chk("abort_x", x0, 4'd0);
    dn = 0;
    repeat (25) begin if (done0) dn++; tick(); end
    chk("abort_no_done", dn, 0);

    // Sync reset at minterm 9.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (9) tick();
    chk("rst_at_m9_x", x0, 4'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_flags", {busy0, done0, match0, cerr0}, 4'b0000);
    chk("rst_mid_tt_x", {tt0, x0}, 20'h0);
    dn = 0;
    repeat (20) begin if (done0) dn++; tick(); end
    chk("rst_mid_no_done", dn, 0);
    run_vec(10, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
